seq_mul: RTL and testbench



---
 rtl/seq_mul_pkg.sv | 22 ++
 rtl/seq_mul_cu.sv | 78 +++++++
 rtl/seq_mul.sv | 106 ++++++++++
 tb/tb_seq_mul.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg : shared constants and state encoding for the shift-add
//               multiplier. Default widths match the divider datapath.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seq_mul_pkg;

  localparam int C_WIDTH = 10;
  localparam int C_FRAC  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_mul_cu.sv
// ---------------------------------------------------------------------------
// seq_mul_cu : controller FSM for seq_mul (accept, iterate, range check).
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mul_cu
  import seq_mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic cnt_done_i,
  input  logic ovf_detect_i,
  output logic ld_o,
  output logic step_o,
  output logic busy_o,
  output logic done_o,
  output logic val_set_o,
  output logic ovf_set_o
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_o      = 1'b0;
    step_o    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    val_set_o = 1'b0;
    ovf_set_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          ld_o    = 1'b1;
          state_d = MULT;
        end
      end
      MULT: begin
        busy_o = 1'b1;
        step_o = 1'b1;
        if (cnt_done_i) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        busy_o    = 1'b1;
        val_set_o = ~ovf_detect_i;
        ovf_set_o = ovf_detect_i;
        state_d   = DONE;
      end
      DONE: begin
        // DONE accepts a new request just like IDLE for back-to-back use
        done_o = 1'b1;
        if (start_i) begin
          ld_o    = 1'b1;
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_mul.sv
// ---------------------------------------------------------------------------
// seq_mul  : sequential shift-add unsigned Q(WIDTH-FRAC).FRAC multiplier,
//            one multiplier bit per clock, truncated re-aligned result.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int FRAC  = C_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] q_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               valid_q, ovf_q;

  logic ld, step, done_st, val_set, ovf_set;
  logic cnt_done, ovf_detect;

  assign cnt_done   = (cnt_q == CNT_W'(WIDTH - 1));
  assign ovf_detect = |acc_q[2*WIDTH-1:WIDTH+FRAC];

  seq_mul_cu u_cu (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .cnt_done_i   (cnt_done),
    .ovf_detect_i (ovf_detect),
    .ld_o         (ld),
    .step_o       (step),
    .busy_o       (busy),
    .done_o       (done_st),
    .val_set_o    (val_set),
    .ovf_set_o    (ovf_set)
  );

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    if (ld) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_in};
      mplier_d = b_in;
      cnt_d    = '0;
    end else if (step) begin
      // Product of two WIDTH-bit values always fits in 2*WIDTH bits
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    if (val_set) begin
      q_d = acc_q[WIDTH+FRAC-1:FRAC];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      valid_q  <= val_set;
      ovf_q    <= ovf_set;
    end
  end

  // Pulses are only ever raised on the CHECK edge, so they coincide with DONE
  assign valid = valid_q & done_st;
  assign ovf   = ovf_q & done_st;
  assign q_out = q_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_seq_mul : directed self-checking bench for seq_mul (WIDTH=10, FRAC=5).
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_mul;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] a_in;
  logic [9:0] b_in;
  logic       busy;
  logic       valid;
  logic       ovf;
  logic [9:0] q_out;

  int n_checks = 0;
  int n_errors = 0;

  seq_mul #(.WIDTH(10), .FRAC(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .valid (valid),
    .ovf   (ovf),
    .q_out (q_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1, "watchdog");
  end

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic start_op(input logic [9:0] a, input logic [9:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = 10'h3ff;
    b_in  = 10'h3ff;
  endtask

  // Counts edges after the accepting edge until valid/ovf (bounded), and busy samples.
  task automatic wait_result(output int edges, output int busy_cnt,
                             output logic v, output logic o);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (edges < 20 && !(valid || ovf)) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    v = valid;
    o = ovf;
    if (!(valid || ovf)) edges = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0)  begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (ovf !== 1'b0)    begin n_errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_checks++; if (q_out !== 10'd0) begin n_errors++; $display("FAIL reset_q: got %0d want 0", q_out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int e, bc; logic v, o;
    start_op(10'd96, 10'd80);
    wait_result(e, bc, v, o);
    n_checks++; if (e !== 11)        begin n_errors++; $display("FAIL basic_latency: got %0d want 11", e); end
    n_checks++; if (bc !== 11)       begin n_errors++; $display("FAIL basic_busy_span: got %0d want 11", bc); end
    n_checks++; if (v !== 1'b1)      begin n_errors++; $display("FAIL basic_valid: got %b want 1", v); end
    n_checks++; if (o !== 1'b0)      begin n_errors++; $display("FAIL basic_ovf: got %b want 0", o); end
    n_checks++; if (q_out !== 10'd240) begin n_errors++; $display("FAIL basic_q: got %0d want 240", q_out); end
    @(posedge clk); #1;
    n_checks++; if (valid !== 1'b0)  begin n_errors++; $display("FAIL basic_pulse_width: got %b want 0", valid); end
  endtask

  task automatic test_overflow();
    int e, bc; logic v, o;
    start_op(10'd512, 10'd512);
    wait_result(e, bc, v, o);
    n_checks++; if (e !== 11)        begin n_errors++; $display("FAIL ovf_latency: got %0d want 11", e); end
    n_checks++; if (o !== 1'b1)      begin n_errors++; $display("FAIL ovf_flag: got %b want 1", o); end
    n_checks++; if (v !== 1'b0)      begin n_errors++; $display("FAIL ovf_valid: got %b want 0", v); end
    n_checks++; if (q_out !== 10'd240) begin n_errors++; $display("FAIL ovf_q_held: got %0d want 240", q_out); end
    @(posedge clk); #1;
    n_checks++; if (ovf !== 1'b0)    begin n_errors++; $display("FAIL ovf_pulse_width: got %b want 0", ovf); end
  endtask

  task automatic test_edge_values();
    int e, bc; logic v, o;
    logic [9:0] av [4] = '{10'd1, 10'd1023, 10'd0,   10'd300};
    logic [9:0] bv [4] = '{10'd1, 10'd32,   10'd500, 10'd0};
    logic [9:0] qv [4] = '{10'd0, 10'd1023, 10'd0,   10'd0};
    for (int i = 0; i < 4; i++) begin
      start_op(av[i], bv[i]);
      wait_result(e, bc, v, o);
      n_checks++; if (e !== 11)    begin n_errors++; $display("FAIL edge%0d_latency: got %0d want 11", i, e); end
      n_checks++; if (v !== 1'b1 || o !== 1'b0)
        begin n_errors++; $display("FAIL edge%0d_flags: got valid=%b ovf=%b want valid=1 ovf=0", i, v, o); end
      n_checks++; if (q_out !== qv[i])
        begin n_errors++; $display("FAIL edge%0d_q: got %0d want %0d", i, q_out, qv[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] av [3] = '{10'd96,  10'd64,  10'd100};
    logic [9:0] bv [3] = '{10'd80,  10'd64,  10'd40};
    logic [9:0] qv [3] = '{10'd240, 10'd128, 10'd125};
    int r = 0;
    a_in = av[0]; b_in = bv[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 40 && r < 3; e++) begin
      @(posedge clk); #1;
      if (valid || ovf) begin
        n_checks++; if (e !== 11 + 12 * r)
          begin n_errors++; $display("FAIL b2b%0d_timing: got edge %0d want %0d", r, e, 11 + 12 * r); end
        n_checks++; if (valid !== 1'b1 || q_out !== qv[r])
          begin n_errors++; $display("FAIL b2b%0d_q: got valid=%b q=%0d want valid=1 q=%0d", r, valid, q_out, qv[r]); end
        r++;
        if (r < 3) begin a_in = av[r]; b_in = bv[r]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    n_checks++; if (r !== 3) begin n_errors++; $display("FAIL b2b_count: got %0d results want 3", r); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy();
    int vedge = 99;
    logic [9:0] qs = '0;
    start_op(10'd100, 10'd40);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (valid && vedge == 99) begin vedge = e; qs = q_out; end
      if (e == 3 || e == 7 || e == 10) begin start = 1'b1; a_in = 10'd1023; b_in = 10'd1023; end
      else start = 1'b0;
      if (e == 12) begin
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_ignore_restart: got busy=%b want 0", busy); end
      end
    end
    n_checks++; if (vedge !== 11)   begin n_errors++; $display("FAIL busy_ignore_timing: got %0d want 11", vedge); end
    n_checks++; if (qs !== 10'd125) begin n_errors++; $display("FAIL busy_ignore_q: got %0d want 125", qs); end
  endtask

  task automatic test_async_reset();
    int e, bc; logic v, o;
    start_op(10'd96, 10'd80);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0 || ovf !== 1'b0 || q_out !== 10'd0)
      begin n_errors++; $display("FAIL async_reset: got busy=%b valid=%b ovf=%b q=%0d want all 0", busy, valid, ovf, q_out); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL async_reset_idle: got busy=%b want 0", busy); end
    start_op(10'd64, 10'd64);
    wait_result(e, bc, v, o);
    n_checks++; if (e !== 11)   begin n_errors++; $display("FAIL post_reset_latency: got %0d want 11", e); end
    n_checks++; if (v !== 1'b1 || q_out !== 10'd128)
      begin n_errors++; $display("FAIL post_reset_q: got valid=%b q=%0d want valid=1 q=128", v, q_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_edge_values();
    test_back_to_back();
    test_start_while_busy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
